// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Issues hold/bubble/flush controls to the stage registers, qualifies the
// ID-stage branch redirect, counts stall cycles and flags fetch timeouts.
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int IMEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_mem_read,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             imem_ready,
    input  logic             cnt_clr,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             bubble_id_ex,
    output logic             bubble_mem_wb,
    output logic             flush_if_id,
    output logic             branch_go,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             imem_err
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        MD_WAIT   = 2'b01,
        IMEM_WAIT = 2'b10
    } state_t;

    // The fetch wait counter is at least 7 bits, wider if the timeout needs it.
    localparam int WAIT_W = ($clog2(IMEM_TIMEOUT + 1) > 7) ? $clog2(IMEM_TIMEOUT + 1) : 7;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_TIMEOUT - 1);

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu_hz;
    logic              br_hz;
    logic              id_hold;
    logic              freeze;
    logic              md_enter;
    logic              fetch_waiting;

    assign state = cur_state;

    // Hazard detection: load-use against EX, branch operands against EX/MEM producers.
    always_comb begin
        lu_hz = ex_mem_read && ex_reg_write && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        br_hz = id_is_branch &&
                ((ex_reg_write && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt))) ||
                 (mem_mem_read && (mem_rd != 5'd0) && ((mem_rd == id_rs) || (mem_rd == id_rt))));
        id_hold       = lu_hz || br_hz;
        md_enter      = md_start && !md_done;
        freeze        = (cur_state == MD_WAIT) ? !md_done : md_enter;
        fetch_waiting = !imem_ready && !freeze;
    end

    // Prioritised pipeline controls; everything is held at zero while in reset.
    always_comb begin
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_mem_wb = 1'b0;
        flush_if_id   = 1'b0;
        branch_go     = 1'b0;
        if (!rst) begin
            if (freeze) begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                stall_id_ex   = 1'b1;
                stall_ex_mem  = 1'b1;
                bubble_mem_wb = 1'b1;
            end else if (id_hold) begin
                stall_pc     = 1'b1;
                stall_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else begin
                if (!imem_ready) begin
                    stall_pc    = 1'b1;
                    flush_if_id = 1'b1;
                end
                if (id_is_branch && branch_taken) begin
                    branch_go   = 1'b1;
                    flush_if_id = 1'b1;
                end
            end
        end
    end

    // Next-state selection: a pending mul/div overrides every other transition.
    always_comb begin
        next_state = cur_state;
        if (md_enter) begin
            next_state = MD_WAIT;
        end else begin
            unique case (cur_state)
                RUN:       if (!imem_ready) next_state = IMEM_WAIT;
                MD_WAIT:   if (md_done)     next_state = RUN;
                IMEM_WAIT: if (imem_ready)  next_state = RUN;
                default:                    next_state = RUN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= RUN;
        end else begin
            cur_state <= next_state;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_pc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Consecutive fetch-wait counter and the sticky timeout flag it drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            imem_err <= 1'b0;
        end else begin
            if (imem_ready || md_enter) begin
                wait_cnt <= '0;
            end else if (fetch_waiting && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (fetch_waiting && (wait_cnt == WAIT_LAST)) begin
                imem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: fixed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W        = 4;
    localparam int IMEM_TIMEOUT = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_HOLD = 8'b1100_1000;
    localparam logic [7:0] C_FRZ  = 8'b1111_0100;
    localparam logic [7:0] C_BR   = 8'b0000_0011;
    localparam logic [7:0] C_IF   = 8'b1000_0010;
    localparam logic [7:0] C_IFBR = 8'b1000_0011;

    typedef struct packed {
        logic       br;
        logic       tk;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] exrd;
        logic       exw;
        logic       exmr;
        logic [4:0] memrd;
        logic       memmr;
        logic       ms;
        logic       md;
        logic       ir;
        logic       clr;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [7:0] ctrl;
        logic [1:0] st;
        int         cnt;
        logic       err;
    } vec_t;

    logic             clk;
    logic             rst;
    stim_t            cur;
    logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic             bubble_id_ex, bubble_mem_wb, flush_if_id, branch_go;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic             imem_err;
    logic [7:0]       act_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_md_busy;
    bit m_fetch_wait;
    int m_wait;
    bit m_err;
    int m_cnt;

    assign act_ctrl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                       bubble_id_ex, bubble_mem_wb, flush_if_id, branch_go};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .IMEM_TIMEOUT(IMEM_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (cur.rs),
        .id_rt        (cur.rt),
        .id_uses_rs   (cur.urs),
        .id_uses_rt   (cur.urt),
        .id_is_branch (cur.br),
        .branch_taken (cur.tk),
        .ex_rd        (cur.exrd),
        .ex_reg_write (cur.exw),
        .ex_mem_read  (cur.exmr),
        .mem_rd       (cur.memrd),
        .mem_mem_read (cur.memmr),
        .md_start     (cur.ms),
        .md_done      (cur.md),
        .imem_ready   (cur.ir),
        .cnt_clr      (cur.clr),
        .stall_pc     (stall_pc),
        .stall_if_id  (stall_if_id),
        .stall_id_ex  (stall_id_ex),
        .stall_ex_mem (stall_ex_mem),
        .bubble_id_ex (bubble_id_ex),
        .bubble_mem_wb(bubble_mem_wb),
        .flush_if_id  (flush_if_id),
        .branch_go    (branch_go),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .imem_err     (imem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mk(input logic br, input logic tk, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs, input logic urt,
                                 input logic [4:0] exrd, input logic exw, input logic exmr,
                                 input logic [4:0] memrd, input logic memmr, input logic ms,
                                 input logic md, input logic ir, input logic clr);
        stim_t s;
        s = '{br, tk, rs, rt, urs, urt, exrd, exw, exmr, memrd, memmr, ms, md, ir, clr};
        return s;
    endfunction

    // Reference: controls derived directly from the hazard and priority rules.
    function automatic logic [7:0] modelCtrl(input stim_t s);
        bit freeze, lu, br_ex, br_mem;
        freeze = m_md_busy ? !s.md : (s.ms && !s.md);
        lu     = s.exmr && s.exw && (s.exrd != 0) &&
                 ((s.urs && s.rs == s.exrd) || (s.urt && s.rt == s.exrd));
        br_ex  = s.exw && (s.exrd != 0) && (s.exrd == s.rs || s.exrd == s.rt);
        br_mem = s.memmr && (s.memrd != 0) && (s.memrd == s.rs || s.memrd == s.rt);
        if (freeze) return C_FRZ;
        if (lu || (s.br && (br_ex || br_mem))) return C_HOLD;
        if (!s.ir && s.br && s.tk) return C_IFBR;
        if (!s.ir) return C_IF;
        if (s.br && s.tk) return C_BR;
        return C_NONE;
    endfunction

    function automatic logic [1:0] modelState();
        if (m_md_busy) return 2'd1;
        if (m_fetch_wait) return 2'd2;
        return 2'd0;
    endfunction

    task automatic modelReset();
        m_md_busy    = 0;
        m_fetch_wait = 0;
        m_wait       = 0;
        m_err        = 0;
        m_cnt        = 0;
    endtask

    // Advance the model across one clock edge with inputs s.
    task automatic modelAdvance(input stim_t s);
        logic [7:0] c;
        bit freeze;
        c      = modelCtrl(s);
        freeze = m_md_busy ? !s.md : (s.ms && !s.md);
        if (s.clr) m_cnt = 0;
        else if (c[7] && m_cnt < CNT_MAX) m_cnt++;
        if (s.ir || (s.ms && !s.md)) m_wait = 0;
        else if (!freeze) begin
            m_wait++;
            if (m_wait >= IMEM_TIMEOUT) m_err = 1;
        end
        if (s.ms && !s.md) begin
            m_md_busy    = 1;
            m_fetch_wait = 0;
        end else if (m_md_busy) begin
            if (s.md) m_md_busy = 0;
        end else begin
            m_fetch_wait = !s.ir;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] ec, input logic [1:0] es,
                            input int ecnt, input logic ee);
        checkOutput({tag, ".ctrl"}, 16'(act_ctrl), 16'(ec));
        checkOutput({tag, ".state"}, 16'(state), 16'(es));
        checkOutput({tag, ".cnt"}, 16'(stall_cnt), 16'(ecnt));
        checkOutput({tag, ".err"}, 16'(imem_err), 16'(ee));
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur = s;
        #2;
    endtask

    task automatic handStep(input string tag, input stim_t s, input logic [7:0] ec,
                            input logic [1:0] es, input int ecnt, input logic ee);
        applyStimulus(s);
        checkAll(tag, ec, es, ecnt, ee);
        modelAdvance(s);
    endtask

    stim_t idle, rst_stim, lu_stim, md_go, md_hold, md_fin, if_stim, if_br;
    vec_t  tbl[13];

    initial begin
        idle     = mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 1,0);
        rst_stim = mk(1,1, 5,5, 1,1, 5,1,1, 5,1, 1,0, 0,0);
        lu_stim  = mk(0,0, 5,2, 1,1, 5,1,1, 0,0, 0,0, 1,0);
        md_go    = mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 1,0, 1,0);
        md_hold  = mk(1,1, 5,2, 1,1, 5,1,1, 0,0, 0,0, 1,0);
        md_fin   = mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 0,1, 1,0);
        if_stim  = mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0);
        if_br    = mk(1,1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0);

        tbl[0]  = '{idle,                                      C_NONE, 2'd0, 0, 1'b0};
        tbl[1]  = '{lu_stim,                                   C_HOLD, 2'd0, 0, 1'b0};
        tbl[2]  = '{idle,                                      C_NONE, 2'd0, 1, 1'b0};
        tbl[3]  = '{mk(0,0, 0,0, 1,1, 0,1,1, 0,0, 0,0, 1,0),   C_NONE, 2'd0, 1, 1'b0};
        tbl[4]  = '{mk(0,0, 1,7, 1,1, 7,1,1, 0,0, 0,0, 1,0),   C_HOLD, 2'd0, 1, 1'b0};
        tbl[5]  = '{mk(0,0, 6,6, 0,0, 6,1,1, 0,0, 0,0, 1,0),   C_NONE, 2'd0, 2, 1'b0};
        tbl[6]  = '{mk(1,1, 1,3, 1,1, 3,1,0, 0,0, 0,0, 1,0),   C_HOLD, 2'd0, 2, 1'b0};
        tbl[7]  = '{mk(1,1, 1,3, 1,1, 3,0,0, 0,0, 0,0, 1,0),   C_BR,   2'd0, 3, 1'b0};
        tbl[8]  = '{mk(1,0, 4,9, 1,1, 0,0,0, 4,1, 0,0, 1,0),   C_HOLD, 2'd0, 3, 1'b0};
        tbl[9]  = '{mk(1,0, 4,9, 1,1, 0,0,0, 4,0, 0,0, 1,0),   C_NONE, 2'd0, 4, 1'b0};
        tbl[10] = '{mk(1,1, 3,8, 0,0, 3,1,0, 0,0, 0,0, 1,0),   C_HOLD, 2'd0, 4, 1'b0};
        tbl[11] = '{mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1),   C_NONE, 2'd0, 5, 1'b0};
        tbl[12] = '{idle,                                      C_NONE, 2'd0, 0, 1'b0};

        // Power-on reset with hazard-provoking inputs: all controls must stay 0.
        rst = 1'b1;
        cur = rst_stim;
        repeat (2) @(negedge clk);
        #2;
        checkAll("reset", C_NONE, 2'd0, 0, 1'b0);
        @(negedge clk);
        cur = idle;
        rst = 1'b0;
        modelReset();
        modelAdvance(idle);

        // Single-cycle hazards from the vector table.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].s);
            checkAll($sformatf("vec%0d", i), tbl[i].ctrl, tbl[i].st, tbl[i].cnt, tbl[i].err);
            modelAdvance(tbl[i].s);
        end

        // Mul/div: 5 frozen cycles, then release with a taken branch.
        handStep("md0", md_go, C_FRZ, 2'd0, 0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            stim_t s;
            s    = md_hold;
            s.ir = (i != 2);
            handStep($sformatf("md%0d", i), s, C_FRZ, 2'd1, i, 1'b0);
        end
        handStep("md_done", md_fin, C_BR, 2'd1, 5, 1'b0);
        handStep("md_after", idle, C_NONE, 2'd0, 5, 1'b0);
        handStep("md_same", mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 1,1, 1,0), C_NONE, 2'd0, 5, 1'b0);
        handStep("md_same2", idle, C_NONE, 2'd0, 5, 1'b0);

        // Fetch wait of 3 cycles with a taken branch on the second.
        handStep("if1", if_stim, C_IF,   2'd0, 5, 1'b0);
        handStep("if2", if_br,   C_IFBR, 2'd2, 6, 1'b0);
        handStep("if3", if_stim, C_IF,   2'd2, 7, 1'b0);
        handStep("if4", idle,    C_NONE, 2'd2, 8, 1'b0);
        handStep("ifclr", mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1), C_NONE, 2'd0, 8, 1'b0);

        // Fetch timeout: error appears after the 4th waiting cycle and sticks.
        for (int i = 0; i < 5; i++) begin
            handStep($sformatf("to%0d", i), if_stim, C_IF, (i == 0) ? 2'd0 : 2'd2, i, i == 4);
        end
        handStep("to_rdy", idle, C_NONE, 2'd2, 5, 1'b1);
        handStep("to_run", idle, C_NONE, 2'd0, 5, 1'b1);

        // Counter saturation and clear-over-increment.
        handStep("sat_clr", mk(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 1,1), C_NONE, 2'd0, 5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            handStep($sformatf("sat%0d", i), lu_stim, C_HOLD, 2'd0, (i < 15) ? i : 15, 1'b1);
        end
        begin
            stim_t s;
            s     = lu_stim;
            s.clr = 1'b1;
            handStep("clr_stall", s, C_HOLD, 2'd0, 15, 1'b1);
        end
        handStep("clr_after", idle, C_NONE, 2'd0, 0, 1'b1);

        // Reset asserted in the middle of a mul/div wait.
        handStep("mdr0", md_go,   C_FRZ, 2'd0, 0, 1'b1);
        handStep("mdr1", md_hold, C_FRZ, 2'd1, 1, 1'b1);
        @(negedge clk);
        cur = md_hold;
        rst = 1'b1;
        #2;
        checkAll("rst_mid", C_NONE, 2'd0, 0, 1'b0);
        @(negedge clk);
        #2;
        checkAll("rst_hold", C_NONE, 2'd0, 0, 1'b0);
        @(negedge clk);
        cur = idle;
        rst = 1'b0;
        modelReset();
        modelAdvance(idle);
        handStep("post_rst0", mk(1,0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 1,0), C_NONE, 2'd0, 0, 1'b0);
        handStep("post_rst1", idle, C_NONE, 2'd0, 0, 1'b0);

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s.br    = 1'($urandom_range(0, 2) == 0);
            s.tk    = 1'($urandom_range(0, 1));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.urs   = 1'($urandom_range(0, 1));
            s.urt   = 1'($urandom_range(0, 1));
            s.exrd  = 5'($urandom_range(0, 3));
            s.exw   = 1'($urandom_range(0, 1));
            s.exmr  = 1'($urandom_range(0, 2) == 0);
            s.memrd = 5'($urandom_range(0, 3));
            s.memmr = 1'($urandom_range(0, 2) == 0);
            s.ms    = 1'($urandom_range(0, 11) == 0);
            s.md    = m_md_busy ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 15) == 0);
            s.ir    = 1'($urandom_range(0, 5) != 0);
            s.clr   = 1'($urandom_range(0, 19) == 0);
            applyStimulus(s);
            checkAll($sformatf("rnd%0d", i), modelCtrl(s), modelState(), m_cnt, m_err);
            modelAdvance(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage pipeline. It sits beside the stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and issues their per-cycle hold, bubble and flush controls. Its inputs are decoded operand/destination fields, a multi-cycle mul/div handshake and the instruction-memory ready signal. It also qualifies ID-stage branch resolution, keeps a saturating stall-cycle counter and raises a sticky instruction-fetch timeout error.

## Interface
- CNT_W, 16, width of stall-cycle counter
- IMEM_TIMEOUT, 64, consecutive imem_ready=0 cycles before imem_err sets (≥1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_rs, id_rt  in  5 each  source register fields of instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_is_branch  in  1  ID instruction is a branch (resolved in ID)
- branch_taken  in  1  raw ID branch comparison result
- ex_rd  in  5  EX-stage destination; ex_reg_write, ex_mem_read  in  1 each
- mem_rd  in  5  MEM-stage destination; mem_mem_read  in  1
- md_start  in  1  EX issues mul/div this cycle (pulse)
- md_done  in  1  mul/div result valid (pulse)
- imem_ready  in  1  fetch data valid this cycle
- cnt_clr  in  1  synchronous clear of stall_cnt
- stall_pc, stall_if_id, stall_id_ex, stall_ex_mem  out  1 each  1 = hold register, 0 = RUN
- bubble_id_ex, bubble_mem_wb  out  1 each  load zeros (NOP) into that register this edge
- flush_if_id  out  1  load zeros into IF/ID (drives its is_branch input)
- branch_go  out  1  qualified redirect; PC unit loads target, overriding stall_pc
- state  out  2  FSM state
- stall_cnt  out  CNT_W  saturating count of cycles with stall_pc=1
- imem_err  out  1  sticky fetch-timeout flag

## Operation
- Control outputs are combinational from state and inputs. state, stall_cnt, wait_cnt (internal, ≥7 bits) and imem_err are registered.
- lu_hz = ex_mem_read & ex_reg_write & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- br_hz = id_is_branch & [(ex_reg_write & ex_rd≠0 & ex_rd∈{id_rs,id_rt}) | (mem_mem_read & mem_rd≠0 & mem_rd∈{id_rs,id_rt})].
- id_hold = lu_hz | br_hz.
- freeze = (state==MD_WAIT & ~md_done) | (state≠MD_WAIT & md_start & ~md_done).
- Per-cycle priority:
  1. freeze: all four stall_* = 1, bubble_mem_wb = 1, all other outputs 0.
  2. id_hold: stall_pc = stall_if_id = 1, bubble_id_ex = 1, branch_go = 0, flush_if_id = 0.
  3. Otherwise, ~imem_ready: stall_pc = 1, flush_if_id = 1. The fetched word is discarded and the PC refetches.
  4. Otherwise, and also combined with 3, branch_taken & id_is_branch: branch_go = 1, flush_if_id = 1.
- All unlisted outputs are 0.
- FSM encoding: RUN = 2'b00, MD_WAIT = 2'b01, IMEM_WAIT = 2'b10.
  - Any state → MD_WAIT if md_start & ~md_done.
  - MD_WAIT → RUN on md_done. In the md_done cycle, outputs follow rules 2–4.
  - RUN → IMEM_WAIT when ~imem_ready and not freezing.
  - IMEM_WAIT → RUN when imem_ready.
  - md_start with md_done in the same cycle: no freeze, stay or return per imem_ready.
- wait_cnt increments each cycle with ~imem_ready & ~freeze. It clears to 0 when imem_ready=1 or on entry to MD_WAIT.
- When wait_cnt reaches IMEM_TIMEOUT−1 while still waiting, imem_err sets at the next edge and stays set until rst.
- stall_cnt increments on stall_pc=1 and saturates at all-ones. cnt_clr has priority over increment.

## Timing
- Hazard response is 0-cycle: stall and flush are valid in the same cycle as their inputs and act at the next clk edge.
- Load-use costs exactly 1 bubble. Afterwards EX holds the NOP, so lu_hz drops with no extra state.
- Mul/div costs N stall cycles, where N = cycles from md_start to md_done (md_done cycle excluded).
- Reset: state = RUN, stall_cnt = 0, wait_cnt = 0, imem_err = 0. While rst=1, all control outputs are forced to 0.
- Reset asserted mid-MD_WAIT or mid-IMEM_WAIT aborts immediately to RUN with all counters cleared.

## Test plan
- Load-use: lw $5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs=5 → one cycle with stall_pc = stall_if_id = bubble_id_ex = 1, stall_cnt = 1. Repeat with ex_rd=0 → no stall.
- Branch hazard: id_is_branch, branch_taken=1, ex_rd=id_rt=3, ex_reg_write=1 → branch_go=0, flush_if_id=0 for 1 cycle. Next cycle (no hazard) → branch_go=1, flush_if_id=1.
- Mul/div: md_start at cycle 10, md_done at cycle 15 → state=01 and all four stalls plus bubble_mem_wb=1 on cycles 10–14. Cycle 15 releases, state=00, stall_cnt=5. Branch_taken during cycles 10–14 → branch_go=0.
- Fetch wait: imem_ready=0 for 3 cycles with branch_taken on the 2nd → stall_pc = flush_if_id = 1 all 3 cycles and branch_go=1 on the 2nd only. With IMEM_TIMEOUT=4 and 5 cycles of imem_ready=0 → imem_err=1 after the 4th waiting cycle, still 1 after imem_ready returns.
- Counter: CNT_W=4, 20 stall cycles → stall_cnt saturates at 15. cnt_clr together with a stall → 0.
- Reset mid-MD_WAIT (rst pulse at cycle 12) → outputs 0 during reset, then state=00, stall_cnt=0, imem_err=0, no stall until the next md_start.
